// File: rtl/fb_scanout.sv
// Framebuffer scan-out: reads the 64x32 1-bpp framebuffer tile by tile
// (8 rows x 8 pixels), transposes each tile into 8 vertical-pixel page
// bytes and streams them out over a valid/ready byte interface.
module fb_scanout #(
  parameter logic [15:0] SCREEN_START = 16'h0100
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_mem_read,
  output logic [15:0] o_mem_addr,
  input  logic [7:0]  i_mem_read_byte,
  output logic        o_out_valid,
  output logic [7:0]  o_out_data,
  output logic        o_out_last,
  input  logic        i_out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_DONE} state_t;

  state_t           r_state, w_state_n;
  logic [1:0]       r_p, w_p_n;
  logic [2:0]       r_c, w_c_n;
  logic [2:0]       r_r, w_r_n;
  logic [2:0]       r_k, w_k_n;
  logic [7:0][7:0]  r_tile, w_tile_n;
  logic             r_busy, w_busy_n;
  logic             r_frame_done, w_frame_done_n;
  logic             r_mem_read, w_mem_read_n;
  logic [15:0]      r_mem_addr, w_mem_addr_n;
  logic             r_out_valid, w_out_valid_n;
  logic [7:0]       r_out_data, w_out_data_n;
  logic             r_out_last, w_out_last_n;
  logic             w_hs;

  // Byte address of framebuffer row (8p+r), byte column c; wraps at 16 bits.
  function automatic logic [15:0] f_addr(input logic [1:0] p, input logic [2:0] r,
                                         input logic [2:0] c);
    return SCREEN_START + {8'h00, p, r, c};
  endfunction

  assign w_hs = r_out_valid & i_out_ready;

  // Next-state and next-output logic; all outputs leave this block registered.
  always_comb begin
    w_state_n      = r_state;
    w_p_n          = r_p;
    w_c_n          = r_c;
    w_r_n          = r_r;
    w_k_n          = r_k;
    w_tile_n       = r_tile;
    w_busy_n       = r_busy;
    w_frame_done_n = 1'b0;
    w_mem_read_n   = 1'b0;
    w_mem_addr_n   = 16'h0000;
    w_out_valid_n  = r_out_valid;
    w_out_data_n   = 8'h00;
    w_out_last_n   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_busy_n     = 1'b1;
          w_p_n        = 2'd0;
          w_c_n        = 3'd0;
          w_r_n        = 3'd0;
          w_k_n        = 3'd0;
          w_mem_read_n = 1'b1;
          w_mem_addr_n = f_addr(2'd0, 3'd0, 3'd0);
          w_state_n    = S_FETCH;
        end
      end
      S_FETCH: begin
        // r_mem_read high marks the wait cycle; data lands the cycle after.
        if (!r_mem_read) begin
          w_tile_n[r_r] = i_mem_read_byte;
          if (r_r != 3'd7) begin
            w_r_n        = r_r + 3'd1;
            w_mem_read_n = 1'b1;
            w_mem_addr_n = f_addr(r_p, w_r_n, r_c);
          end else begin
            w_k_n         = 3'd0;
            w_out_valid_n = 1'b1;
            w_state_n     = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (w_hs) begin
          if (r_k != 3'd7) begin
            w_k_n = r_k + 3'd1;
          end else if (r_out_last) begin
            w_out_valid_n  = 1'b0;
            w_frame_done_n = 1'b1;
            w_state_n      = S_DONE;
          end else begin
            {w_p_n, w_c_n} = {r_p, r_c} + 5'd1;
            w_r_n          = 3'd0;
            w_k_n          = 3'd0;
            w_out_valid_n  = 1'b0;
            w_mem_read_n   = 1'b1;
            w_mem_addr_n   = f_addr(w_p_n, 3'd0, w_c_n);
            w_state_n      = S_FETCH;
          end
        end
      end
      default: begin
        w_busy_n  = 1'b0;
        w_state_n = S_IDLE;
      end
    endcase
    // Column k of the tile becomes one page byte: row j -> bit j.
    if (w_out_valid_n) begin
      for (int j = 0; j < 8; j++) w_out_data_n[j] = w_tile_n[j][~w_k_n];
      w_out_last_n = (w_p_n == 2'd3) && (w_c_n == 3'd7) && (w_k_n == 3'd7);
    end
  end

  // State register; reset aborts any frame in progress.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_p          <= 2'd0;
      r_c          <= 3'd0;
      r_r          <= 3'd0;
      r_k          <= 3'd0;
      r_tile       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_addr   <= 16'h0000;
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'h00;
      r_out_last   <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_p          <= w_p_n;
      r_c          <= w_c_n;
      r_r          <= w_r_n;
      r_k          <= w_k_n;
      r_tile       <= w_tile_n;
      r_busy       <= w_busy_n;
      r_frame_done <= w_frame_done_n;
      r_mem_read   <= w_mem_read_n;
      r_mem_addr   <= w_mem_addr_n;
      r_out_valid  <= w_out_valid_n;
      r_out_data   <= w_out_data_n;
      r_out_last   <= w_out_last_n;
    end
  end

  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_mem_read   = r_mem_read;
  assign o_mem_addr   = r_mem_addr;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_out_last   = r_out_last;

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Framebuffer scan-out stage, directly downstream of the sprite-drawing GPU.
- Reads the 64x32 1-bpp CHIP-8 framebuffer (256 bytes, row-major, 8 bytes per row, MSB = leftmost pixel) over the shared byte-wide memory port.
- Transposes it into SSD1306-style page format: 4 pages x 64 columns = 256 bytes, each byte holding 8 vertical pixels, bit0 = top.
- Streams the result to the display driver over a valid/ready byte stream. Top level grants the memory port to this block only while busy=1 and starts it only when the GPU is idle.

Parameters:
- screen_start, 'h100, base address of framebuffer byte for pixel (0,0).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request one full-frame scan; sampled only in IDLE
- busy  out  1  high from the edge accepting start until the frame completes
- frame_done  out  1  one-cycle pulse after the final byte is accepted
- mem_read  out  1  one-cycle read strobe
- mem_addr  out  16  read address; 0 when mem_read=0
- mem_read_byte  in  8  read data, valid on the second rising edge after the edge that raised mem_read
- out_valid  out  1  out_data valid
- out_data  out  8  page-format byte
- out_last  out  1  high with byte 255 of the frame
- out_ready  in  1  consumer accepts when out_valid & out_ready at a rising edge

Behaviour:
- Reset: state IDLE; busy, frame_done, mem_read, out_valid, out_last = 0; mem_addr, out_data = 0; internal counters and tile buffer cleared.
  - Reset mid-frame aborts immediately. No partial-frame resume.
  - The next start begins at byte 0.
- Counters:
  - page p (2 bits, 0..3)
  - column group c (3 bits, 0..7)
  - row r (3 bits, 0..7)
  - column k (3 bits, 0..7)
- Output order: p outer, c, then k inner. Byte index = p*64 + c*8 + k, giving SSD1306 horizontal addressing.
- States:
  - IDLE
    - If start: busy<=1; p, c, r, k <= 0.
    - Issue read: mem_read<=1, mem_addr<=screen_start + (8p+r)*8 + c.
    - Go to FETCH.
  - FETCH
    - Cycle after issue: wait, as mem_read is being cleared.
    - Next cycle: capture mem_read_byte into tile row r.
    - If r<7: r<=r+1 and issue next read.
    - Else: go to EMIT with k=0.
    - Exactly 8 non-overlapping reads per tile, 16 cycles per tile fetch.
  - EMIT
    - out_valid=1.
    - out_data bit j = bit (7-k) of tile row j, j=0..7.
    - out_last = (p==3 && c==7 && k==7).
    - On handshake with k<7: k<=k+1.
    - On handshake with k==7:
      - If not last: advance c (wrap to 0 and increment p), r<=0, issue next read, go to FETCH.
      - If last: go to DONE.
  - DONE
    - frame_done<=1 for one cycle, busy<=0, go to IDLE.
- Stall behaviour: while out_valid & !out_ready, out_data/out_last/out_valid are held stable and no memory reads are issued.
- Handshake rules:
  - out_valid never drops without a handshake.
  - mem_read is never high outside FETCH.
- Address arithmetic: 16-bit, wraps modulo 2^16. Rows are 8p+r, in 0..31.
- start while busy is ignored. start in the same cycle that frame_done is asserted is ignored; the next frame needs start in IDLE.
- Timing:
  - With start accepted at edge E0 and out_ready tied high, first out_valid is visible after E16.
  - Full frame = 32 tiles x (16+8) = 768 cycles from E0 to the last handshake.
  - frame_done is high the cycle after the last handshake.
- No memory writes. The block never modifies the framebuffer.

Test Plan:
- Reset then start with all-zero framebuffer, out_ready=1 -> 256 bytes of 0x00; out_last only on byte 256; frame_done 1 cycle after; busy low after; 768 cycles E0 to last handshake.
- Framebuffer byte screen_start+0 = 0x80 (pixel 0,0), rest 0 -> output byte 0 = 0x01, all others 0x00.
- Column 63 of rows 24..31 set (bytes at screen_start + row*8 + 7 = 0x01) -> byte 255 = 0xFF with out_last=1; all others 0.
- Checkerboard rows alternating 0xAA/0x55 -> every byte alternates 0x55 (k even) / 0xAA (k odd); mem_addr sequence = screen_start + 0, 8, 16 ... 56, then +1, 9, ... per tile.
- Random out_ready backpressure plus start pulses while busy -> data stable during stall, no reads during EMIT, exactly one frame produced, byte stream matches reference model.
- Assert reset at byte 100 mid-stream -> all outputs 0 on the same edge; new start yields a full correct 256-byte frame from byte 0.
